// File: rtl/qmc_fixed_pkg.sv
// Shared fixed-point definitions for the QMC inverse-CDF front end.
package qmc_fixed_pkg;

    localparam int Q_WIDTH = 32;
    localparam int Q_FRAC  = 16;

    // 0.5 and 1.0 in unsigned Q(Q_WIDTH-Q_FRAC).Q_FRAC
    localparam logic [Q_WIDTH-1:0] Q_HALF = Q_WIDTH'(1) << (Q_FRAC - 1);
    localparam logic [Q_WIDTH-1:0] Q_ONE  = Q_WIDTH'(1) << Q_FRAC;

    // Per-lane fold result; x is carried at package width, narrower lanes zero-extend
    typedef struct packed {
        logic [Q_WIDTH-1:0] x;
        logic               negate;
        logic               tail;
        logic               clamped;
    } fold_lane_t;

    // MAIN/SKID occupancy of the output buffer
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_t;

    function automatic int unsigned popcount(input logic [63:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 64; i++) n += 32'(v[i]);
        return n;
    endfunction

endpackage

// File: rtl/inverse_cdf_fold_lane.sv
// One lane of the fold: clamp degenerate u, fold about 0.5, flag the lower tail.
module inverse_cdf_fold_lane
    import qmc_fixed_pkg::*;
#(
    parameter int WIDTH   = Q_WIDTH,
    parameter int QFRAC   = Q_FRAC,
    parameter int EPS_LSB = 1,
    parameter int P_LOW   = 1589
) (
    input  logic [WIDTH-1:0] u,
    output fold_lane_t       lane
);

    localparam logic [WIDTH-1:0] HALF = WIDTH'(1) << (QFRAC - 1);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1) << QFRAC;
    localparam logic [WIDTH-1:0] EPS  = WIDTH'(EPS_LSB);
    localparam logic [WIDTH-1:0] HI   = ONE - EPS;
    localparam logic [WIDTH-1:0] PLOW = WIDTH'(P_LOW);

    logic [WIDTH-1:0] x;
    logic             negate;
    logic             clamped;

    // Clamp first so ONE-u below can never wrap
    always_comb begin
        x       = u;
        negate  = 1'b0;
        clamped = 1'b0;
        if (u < EPS) begin
            x       = EPS;
            negate  = 1'b1;
            clamped = 1'b1;
        end else if (u > HI) begin
            x       = EPS;
            clamped = 1'b1;
        end else if (u < HALF) begin
            negate  = 1'b1;
        end else begin
            x       = ONE - u;
        end
    end

    assign lane.x       = Q_WIDTH'(x);
    assign lane.negate  = negate;
    assign lane.tail    = (x < PLOW);
    assign lane.clamped = clamped;

endmodule

// File: rtl/inverse_cdf_fold_multi.sv
// Multi-lane fold front end with a MAIN+SKID output buffer and clamp statistics.
module inverse_cdf_fold_multi
    import qmc_fixed_pkg::*;
#(
    parameter int NLANES  = 4,
    parameter int WIDTH   = Q_WIDTH,
    parameter int QFRAC   = Q_FRAC,
    parameter int EPS_LSB = 1,
    parameter int P_LOW   = 1589,
    parameter int CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NLANES*WIDTH-1:0] in_u,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [NLANES*WIDTH-1:0] out_x,
    output logic [NLANES-1:0]       out_negate,
    output logic [NLANES-1:0]       out_tail,
    output logic [NLANES-1:0]       out_clamped,
    input  logic                    clr_stats,
    output logic [CNT_W-1:0]        clamp_cnt
);

    localparam int SUM_W = CNT_W + 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    fold_lane_t                     fold [NLANES];
    logic [NLANES-1:0][WIDTH-1:0]   in_x, main_x, skid_x;
    logic [NLANES-1:0]              in_neg, in_tail, in_clamp;
    logic [NLANES-1:0]              main_neg, main_tail, main_clamp;
    logic [NLANES-1:0]              skid_neg, skid_tail, skid_clamp;

    buf_state_t state, state_nx;
    logic       accept, consume;
    logic       load_main, main_from_skid, load_skid;
    logic [SUM_W-1:0] cnt_sum;

    for (genvar g = 0; g < NLANES; g++) begin : g_lane
        inverse_cdf_fold_lane #(
            .WIDTH   (WIDTH),
            .QFRAC   (QFRAC),
            .EPS_LSB (EPS_LSB),
            .P_LOW   (P_LOW)
        ) u_lane (
            .u    (in_u[g*WIDTH +: WIDTH]),
            .lane (fold[g])
        );
        assign in_x[g]     = WIDTH'(fold[g].x);
        assign in_neg[g]   = fold[g].negate;
        assign in_tail[g]  = fold[g].tail;
        assign in_clamp[g] = fold[g].clamped;
    end

    // Ready depends only on buffer state (and reset), never on out_ready
    assign in_ready  = rst | (state != BUF_FULL);
    assign out_valid = (state != BUF_EMPTY);
    assign accept    = in_valid & in_ready;
    assign consume   = out_valid & out_ready;

    // Buffer occupancy register
    always_ff @(posedge clk) begin
        if (rst) state <= BUF_EMPTY;
        else     state <= state_nx;
    end

    // Next occupancy and which register loads this cycle
    always_comb begin
        state_nx       = state;
        load_main      = 1'b0;
        main_from_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            BUF_EMPTY: begin
                if (accept) begin
                    load_main = 1'b1;
                    state_nx  = BUF_ONE;
                end
            end
            BUF_ONE: begin
                if (accept && consume) begin
                    load_main = 1'b1;
                end else if (accept) begin
                    load_skid = 1'b1;
                    state_nx  = BUF_FULL;
                end else if (consume) begin
                    state_nx  = BUF_EMPTY;
                end
            end
            BUF_FULL: begin
                if (consume) begin
                    main_from_skid = 1'b1;
                    state_nx       = BUF_ONE;
                end
            end
            default: state_nx = BUF_EMPTY;
        endcase
    end

    // MAIN and SKID data; reset clears both so the outputs read zero
    always_ff @(posedge clk) begin
        if (rst) begin
            main_x <= '0; main_neg <= '0; main_tail <= '0; main_clamp <= '0;
            skid_x <= '0; skid_neg <= '0; skid_tail <= '0; skid_clamp <= '0;
        end else begin
            if (load_main) begin
                main_x <= in_x; main_neg <= in_neg; main_tail <= in_tail; main_clamp <= in_clamp;
            end else if (main_from_skid) begin
                main_x <= skid_x; main_neg <= skid_neg; main_tail <= skid_tail; main_clamp <= skid_clamp;
            end
            if (load_skid) begin
                skid_x <= in_x; skid_neg <= in_neg; skid_tail <= in_tail; skid_clamp <= in_clamp;
            end
        end
    end

    assign out_x       = main_x;
    assign out_negate  = main_neg;
    assign out_tail    = main_tail;
    assign out_clamped = main_clamp;

    assign cnt_sum = SUM_W'(clamp_cnt) + SUM_W'(popcount(64'(in_clamp)));

    // Saturating clamp counter; clear wins over a same-cycle increment
    always_ff @(posedge clk) begin
        if (rst || clr_stats) clamp_cnt <= '0;
        else if (accept)      clamp_cnt <= (cnt_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : cnt_sum[CNT_W-1:0];
    end

endmodule

// File: tb/tb_inverse_cdf_fold_multi.sv
// Scoreboard bench for inverse_cdf_fold_multi.
module tb_inverse_cdf_fold_multi;
    import qmc_fixed_pkg::*;

    typedef struct packed {
        logic [127:0] x;
        logic [3:0]   neg;
        logic [3:0]   tail;
        logic [3:0]   clmp;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, out_valid, out_ready, clr_stats;
    logic [127:0] in_u, out_x;
    logic [3:0]   out_negate, out_tail, out_clamped;
    logic [15:0]  clamp_cnt;

    logic         v4, rdy4, clr4, ordy4, ov4;
    logic [127:0] u4, x4;
    logic [3:0]   n4, t4, c4, cnt4;

    int n_cmp = 0, n_bad = 0;
    int n_in = 0, n_out = 0;
    int unsigned ref_clamps = 0;
    beat_t sb[$];

    always #5 clk = ~clk;

    inverse_cdf_fold_multi dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_u(in_u),
        .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_negate(out_negate),
        .out_tail(out_tail), .out_clamped(out_clamped), .clr_stats(clr_stats), .clamp_cnt(clamp_cnt)
    );

    inverse_cdf_fold_multi #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(v4), .in_ready(rdy4), .in_u(u4),
        .out_valid(ov4), .out_ready(ordy4), .out_x(x4), .out_negate(n4),
        .out_tail(t4), .out_clamped(c4), .clr_stats(clr4), .clamp_cnt(cnt4)
    );

    // Reference fold written from the arithmetic definition at QFRAC=16, EPS=1
    function automatic beat_t model(input logic [127:0] u);
        beat_t b;
        logic [31:0] l, x;
        b = '0;
        for (int i = 0; i < 4; i++) begin
            l = u[i*32 +: 32];
            if (l == 32'd0) begin
                x = 32'd1; b.neg[i] = 1'b1; b.clmp[i] = 1'b1;
            end else if (l >= Q_ONE) begin
                x = 32'd1; b.clmp[i] = 1'b1;
            end else if (l < Q_HALF) begin
                x = l; b.neg[i] = 1'b1;
            end else begin
                x = 32'h0001_0000 - l;
            end
            b.x[i*32 +: 32] = x;
            b.tail[i] = (x < 32'd1589);
        end
        return b;
    endfunction

    function automatic logic [31:0] rand_lane();
        case ($urandom_range(0, 9))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF;
            3: return 32'h1_0000;
            4: return $urandom;
            5: return 32'h8000;
            6: return $urandom_range(0, 1600);
            default: return $urandom_range(0, 32'h1_0000);
        endcase
    endfunction

    function automatic logic [127:0] rand_beat();
        return {rand_lane(), rand_lane(), rand_lane(), rand_lane()};
    endfunction

    // One clock: observe handshakes at the falling edge, update the scoreboard, then step
    task automatic tick(output bit acc, output bit cons, output beat_t got, output beat_t exp, output bit have_exp);
        beat_t m;
        @(negedge clk);
        acc = in_valid & in_ready & !rst;
        cons = out_valid & out_ready & !rst;
        have_exp = 1'b0; exp = '0; got = '0;
        m = model(in_u);
        if (cons) begin
            got.x = out_x; got.neg = out_negate; got.tail = out_tail; got.clmp = out_clamped;
            n_out++;
            if (sb.size() > 0) begin exp = sb.pop_front(); have_exp = 1'b1; end
        end
        if (rst) sb.delete();
        else if (acc) begin sb.push_back(m); n_in++; end
        if (rst || clr_stats) ref_clamps = 0;
        else if (acc) ref_clamps += $countones(m.clmp);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        bit a, c, he; beat_t g, e;
        rst = 1'b1; in_valid = 1'b1; in_u = {4{32'h1234}}; out_ready = 1'b1; clr_stats = 1'b0;
        v4 = 1'b0; u4 = '0; clr4 = 1'b0; ordy4 = 1'b1;
        repeat (3) tick(a, c, g, e, he);
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        n_cmp++; if ({out_x, out_negate, out_tail, out_clamped} !== '0) begin n_bad++; $display("FAIL rst_outputs got x=%h n=%b t=%b c=%b exp all 0", out_x, out_negate, out_tail, out_clamped); end
        n_cmp++; if (clamp_cnt !== 16'd0 || cnt4 !== 4'd0) begin n_bad++; $display("FAIL rst_clamp_cnt got=%0d/%0d exp=0", clamp_cnt, cnt4); end
        rst = 1'b0; in_valid = 1'b0;
        tick(a, c, g, e, he);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_discard got out_valid=%b exp=0", out_valid); end
    endtask

    task automatic test_basic();
        bit a, c, he; beat_t g, e;
        out_ready = 1'b1; in_valid = 1'b1; in_u = {32'h4000, 32'h8000, 32'hC000, 32'h0100};
        tick(a, c, g, e, he);
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL basic_latency got out_valid=%b exp=1", out_valid); end
        n_cmp++; if (out_x !== {32'h4000, 32'h8000, 32'h4000, 32'h0100}) begin n_bad++; $display("FAIL basic_x got=%h exp=%h", out_x, {32'h4000, 32'h8000, 32'h4000, 32'h0100}); end
        n_cmp++; if ({out_negate, out_tail, out_clamped} !== {4'b1001, 4'b0001, 4'b0000}) begin n_bad++; $display("FAIL basic_flags got n=%b t=%b c=%b exp n=1001 t=0001 c=0000", out_negate, out_tail, out_clamped); end
        tick(a, c, g, e, he);
        n_cmp++; if (!c || !he || g !== e) begin n_bad++; $display("FAIL basic_sb got c=%b x=%h n=%b t=%b cl=%b exp x=%h n=%b t=%b cl=%b", c, g.x, g.neg, g.tail, g.clmp, e.x, e.neg, e.tail, e.clmp); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_drain got out_valid=%b exp=0", out_valid); end
    endtask

    task automatic test_clamp();
        bit a, c, he; beat_t g, e;
        out_ready = 1'b1; in_valid = 1'b1; in_u = {32'h0000, 32'h1_0000, 32'hFFFF, 32'h0001};
        tick(a, c, g, e, he);
        in_valid = 1'b0;
        n_cmp++; if (out_x !== {4{32'h1}}) begin n_bad++; $display("FAIL clamp_x got=%h exp=%h", out_x, {4{32'h1}}); end
        n_cmp++; if ({out_negate, out_clamped, out_tail} !== {4'b1001, 4'b1100, 4'b1111}) begin n_bad++; $display("FAIL clamp_flags got n=%b c=%b t=%b exp n=1001 c=1100 t=1111", out_negate, out_clamped, out_tail); end
        n_cmp++; if (clamp_cnt !== 16'd2 || clamp_cnt !== 16'(ref_clamps)) begin n_bad++; $display("FAIL clamp_cnt got=%0d exp=2 ref=%0d", clamp_cnt, ref_clamps); end
        tick(a, c, g, e, he);
        n_cmp++; if (!c || !he || g !== e) begin n_bad++; $display("FAIL clamp_sb got c=%b x=%h n=%b t=%b cl=%b exp x=%h n=%b t=%b cl=%b", c, g.x, g.neg, g.tail, g.clmp, e.x, e.neg, e.tail, e.clmp); end
    endtask

    task automatic test_backpressure();
        bit a, c, he; beat_t g, e;
        logic [127:0] ua, ub, uc;
        int outs;
        ua = {32'h0100, 32'h0200, 32'h0300, 32'h0400};
        ub = {32'h9000, 32'hA000, 32'hB000, 32'hFFF0};
        uc = {32'h0000, 32'h2000, 32'h1_0005, 32'h7FFF};
        out_ready = 1'b0; in_valid = 1'b1; in_u = ua;
        tick(a, c, g, e, he);
        in_u = ub;
        tick(a, c, g, e, he);
        n_cmp++; if (!a) begin n_bad++; $display("FAIL bp_accept_b got acc=%b exp=1", a); end
        n_cmp++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_full got in_ready=%b out_valid=%b exp 0/1", in_ready, out_valid); end
        in_u = uc;
        for (int i = 0; i < 2; i++) begin
            tick(a, c, g, e, he);
            n_cmp++; if (a || out_x !== model(ua).x) begin n_bad++; $display("FAIL bp_stall got acc=%b x=%h exp acc=0 x=%h", a, out_x, model(ua).x); end
        end
        out_ready = 1'b1; outs = 0;
        for (int cyc = 0; cyc < 20 && outs < 3; cyc++) begin
            tick(a, c, g, e, he);
            if (a) in_valid = 1'b0;
            if (c) begin
                outs++;
                n_cmp++; if (!he || g !== e) begin n_bad++; $display("FAIL bp_order got x=%h n=%b t=%b cl=%b exp x=%h n=%b t=%b cl=%b", g.x, g.neg, g.tail, g.clmp, e.x, e.neg, e.tail, e.clmp); end
            end
        end
        in_valid = 1'b0;
        tick(a, c, g, e, he);
        n_cmp++; if (outs != 3 || c) begin n_bad++; $display("FAIL bp_count got outs=%0d extra=%b exp 3/0", outs, c); end
    endtask

    task automatic test_random();
        bit a, c, he; beat_t g, e;
        int sent;
        in_valid = 1'b0; clr_stats = 1'b1;
        tick(a, c, g, e, he);
        clr_stats = 1'b0; n_in = 0; n_out = 0; sent = 0;
        in_u = rand_beat();
        for (int cyc = 0; cyc < 3000 && (sent < 100 || sb.size() > 0); cyc++) begin
            in_valid = (sent < 100);
            out_ready = $urandom_range(0, 1);
            tick(a, c, g, e, he);
            if (a) begin sent++; in_u = rand_beat(); end
            if (c) begin
                n_cmp++; if (!he || g !== e) begin n_bad++; $display("FAIL rand_sb got x=%h n=%b t=%b cl=%b exp x=%h n=%b t=%b cl=%b", g.x, g.neg, g.tail, g.clmp, e.x, e.neg, e.tail, e.clmp); end
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_cmp++; if (sent != 100 || sb.size() != 0) begin n_bad++; $display("FAIL rand_timeout got sent=%0d pending=%0d exp 100/0", sent, sb.size()); end
        n_cmp++; if (n_in != n_out || n_out != 100) begin n_bad++; $display("FAIL rand_count got in=%0d out=%0d exp 100/100", n_in, n_out); end
        n_cmp++; if (clamp_cnt !== 16'(ref_clamps)) begin n_bad++; $display("FAIL rand_clamp_cnt got=%0d exp=%0d", clamp_cnt, ref_clamps); end
    endtask

    task automatic test_saturate();
        u4 = '0; v4 = 1'b1; ordy4 = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        n_cmp++; if (cnt4 !== 4'd12) begin n_bad++; $display("FAIL sat_partial got=%0d exp=12", cnt4); end
        repeat (17) begin @(posedge clk); #1; end
        n_cmp++; if (cnt4 !== 4'd15) begin n_bad++; $display("FAIL sat_cap got=%0d exp=15", cnt4); end
        clr4 = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (cnt4 !== 4'd0) begin n_bad++; $display("FAIL sat_clr_priority got=%0d exp=0", cnt4); end
        clr4 = 1'b0;
        @(posedge clk); #1;
        v4 = 1'b0;
        n_cmp++; if (cnt4 !== 4'd4) begin n_bad++; $display("FAIL sat_resume got=%0d exp=4", cnt4); end
    endtask

    task automatic test_reset_full();
        bit a, c, he; beat_t g, e;
        int stale;
        out_ready = 1'b0; in_valid = 1'b1; in_u = {32'h0000, 32'h0000, 32'h3000, 32'h9000};
        tick(a, c, g, e, he);
        in_u = {32'h1_0000, 32'h5000, 32'h6000, 32'h0010};
        tick(a, c, g, e, he);
        n_cmp++; if (in_ready !== 1'b0 || clamp_cnt == 16'd0) begin n_bad++; $display("FAIL rf_setup got in_ready=%b cnt=%0d exp 0/nonzero", in_ready, clamp_cnt); end
        rst = 1'b1;
        tick(a, c, g, e, he);
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL rf_handshake got out_valid=%b in_ready=%b exp 0/1", out_valid, in_ready); end
        n_cmp++; if (clamp_cnt !== 16'd0 || out_x !== '0) begin n_bad++; $display("FAIL rf_clear got cnt=%0d x=%h exp 0/0", clamp_cnt, out_x); end
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; stale = 0;
        repeat (6) begin
            tick(a, c, g, e, he);
            if (c) stale++;
        end
        n_cmp++; if (stale != 0) begin n_bad++; $display("FAIL rf_stale got=%0d exp=0", stale); end
        in_valid = 1'b1; in_u = {32'h7000, 32'h8001, 32'h0005, 32'hF000};
        tick(a, c, g, e, he);
        in_valid = 1'b0;
        tick(a, c, g, e, he);
        n_cmp++; if (!c || !he || g !== e) begin n_bad++; $display("FAIL rf_fresh got c=%b x=%h n=%b exp x=%h n=%b", c, g.x, g.neg, e.x, e.neg); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_clamp();
        test_backpressure();
        test_random();
        test_saturate();
        test_reset_full();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
